mesh_route_stage: RTL and testbench

- Input stage of a mesh router. Consumes PCKG_SZ-bit packets from the terminal/bus handler and buffers them in a FIFO.
- Computes the output direction for each packet using dimension-ordered routing. The packet's mode bit selects row-first or column-first ordering.
- Rewrites the next-jump field with the neighbour's coordinates and presents the packet to the crossbar through a registered valid/ready output.
- Drops packets whose target lies outside the mesh.

---
 rtl/mesh_pkg.sv | 83 ++++++++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mesh_route_stage.sv | 138 +++++++++++++
 tb/tb_mesh_route_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared types and helpers for the mesh router ports: packet field offsets,
// direction encodings and the dimension-ordered route function.
package mesh_pkg;

  typedef logic [3:0] coord_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } route_state_e;

  localparam logic [4:0] DIR_N = 5'b00001;
  localparam logic [4:0] DIR_S = 5'b00010;
  localparam logic [4:0] DIR_E = 5'b00100;
  localparam logic [4:0] DIR_W = 5'b01000;
  localparam logic [4:0] DIR_L = 5'b10000;

  typedef struct packed {
    logic [4:0] dir;
    logic [7:0] nxt_jump;
  } route_t;

  // Field positions are counted down from the packet MSB.
  function automatic int nxt_jump_lsb(input int p);
    return p - 8;
  endfunction

  function automatic int trgt_r_lsb(input int p);
    return p - 12;
  endfunction

  function automatic int trgt_c_lsb(input int p);
    return p - 16;
  endfunction

  function automatic int mode_pos(input int p);
    return p - 17;
  endfunction

  function automatic route_t route_calc(input coord_t trgt_r, input coord_t trgt_c,
                                        input logic mode, input coord_t id_r,
                                        input coord_t id_c);
    route_t r;
    coord_t r_dec;
    coord_t r_inc;
    coord_t c_dec;
    coord_t c_inc;
    r_dec = id_r - 4'd1;
    r_inc = id_r + 4'd1;
    c_dec = id_c - 4'd1;
    c_inc = id_c + 4'd1;
    r.dir      = DIR_L;
    r.nxt_jump = {id_r, id_c};
    if (trgt_r == id_r && trgt_c == id_c) begin
      r.dir      = DIR_L;
      r.nxt_jump = {id_r, id_c};
    end else if (mode && trgt_r != id_r) begin
      if (trgt_r < id_r) begin
        r.dir      = DIR_N;
        r.nxt_jump = {r_dec, id_c};
      end else begin
        r.dir      = DIR_S;
        r.nxt_jump = {r_inc, id_c};
      end
    end else if (trgt_c != id_c) begin
      if (trgt_c > id_c) begin
        r.dir      = DIR_E;
        r.nxt_jump = {id_r, c_inc};
      end else begin
        r.dir      = DIR_W;
        r.nxt_jump = {id_r, c_dec};
      end
    end else if (trgt_r < id_r) begin
      r.dir      = DIR_N;
      r.nxt_jump = {r_dec, id_c};
    end else begin
      r.dir      = DIR_S;
      r.nxt_jump = {r_inc, id_c};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and occupancy count; shared by
// all router input ports.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mesh_route_stage.sv
// Mesh router input stage: buffers packets, routes them dimension-ordered,
// rewrites the next-jump field and drops packets addressed off-mesh.
module mesh_route_stage
  import mesh_pkg::*;
#(
  parameter int PCKG_SZ    = 50,
  parameter int FIFO_DEPTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    id_r,
  input  logic [3:0]                    id_c,
  input  logic [PCKG_SZ-1:0]            in_data,
  input  logic                          in_vld,
  output logic                          in_rdy,
  output logic [PCKG_SZ-1:0]            out_data,
  output logic [4:0]                    out_dir,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          drop_err,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int NJ_LSB = nxt_jump_lsb(PCKG_SZ);
  localparam int TR_LSB = trgt_r_lsb(PCKG_SZ);
  localparam int TC_LSB = trgt_c_lsb(PCKG_SZ);
  localparam int MD_POS = mode_pos(PCKG_SZ);

  route_state_e        state_q, state_d;
  logic [PCKG_SZ-1:0]  out_data_q, out_data_d;
  logic [4:0]          out_dir_q, out_dir_d;
  logic                drop_err_q, drop_err_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                in_rdy_q, in_rdy_d;
  logic                push_q, push_d;

  logic [PCKG_SZ-1:0]  head;
  logic [PCKG_SZ-1:0]  rewritten;
  logic                fifo_full, fifo_empty;
  logic                push, pop, avail, is_drop;
  coord_t              trgt_r, trgt_c;
  route_t              rt;

  assign push = in_vld && in_rdy_q;

  sync_fifo #(
    .WIDTH (PCKG_SZ),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // An entry written at the last edge is not yet eligible to pop, giving
  // the two-edge accept-to-present latency without a bypass path.
  assign avail = !fifo_empty && !(push_q && int'(fifo_cnt) == 1);
  assign pop   = avail && (state_q == ST_EMPTY || out_rdy);

  assign trgt_r  = head[TR_LSB +: 4];
  assign trgt_c  = head[TC_LSB +: 4];
  assign is_drop = (int'(trgt_r) >= ROWS) || (int'(trgt_c) >= COLS);
  assign rt      = route_calc(trgt_r, trgt_c, head[MD_POS], id_r, id_c);

  always_comb begin
    rewritten                 = head;
    rewritten[NJ_LSB +: 8]    = rt.nxt_jump;
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_dir_d  = out_dir_q;
    drop_err_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
    push_d     = push;
    in_rdy_d   = 1'b1;
    if (fifo_full) begin
      in_rdy_d = pop;
    end else if (int'(fifo_cnt) == FIFO_DEPTH - 1 && push && !pop) begin
      in_rdy_d = 1'b0;
    end
    if (state_q == ST_FULL && out_rdy) begin
      state_d    = ST_EMPTY;
      out_data_d = '0;
      out_dir_d  = '0;
    end
    if (pop) begin
      if (is_drop) begin
        drop_err_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end else begin
        state_d    = ST_FULL;
        out_data_d = rewritten;
        out_dir_d  = rt.dir;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_dir_q  <= '0;
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
      in_rdy_q   <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_dir_q  <= out_dir_d;
      drop_err_q <= drop_err_d;
      drop_cnt_q <= drop_cnt_d;
      in_rdy_q   <= in_rdy_d;
      push_q     <= push_d;
    end
  end

  assign out_vld  = (state_q == ST_FULL);
  assign out_data = out_data_q;
  assign out_dir  = out_dir_q;
  assign drop_err = drop_err_q;
  assign drop_cnt = drop_cnt_q;
  assign in_rdy   = in_rdy_q;

endmodule

// File: tb/tb_mesh_route_stage.sv
// Directed bench for mesh_route_stage: router (1,2) in a 4x4 mesh.
module tb_mesh_route_stage;

  localparam int P = 50;
  localparam logic [4:0] EXP_N = 5'b00001;
  localparam logic [4:0] EXP_S = 5'b00010;
  localparam logic [4:0] EXP_E = 5'b00100;
  localparam logic [4:0] EXP_W = 5'b01000;
  localparam logic [4:0] EXP_L = 5'b10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   id_r = 4'd1;
  logic [3:0]   id_c = 4'd2;
  logic [P-1:0] in_data = '0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [P-1:0] out_data;
  logic [4:0]   out_dir;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic         drop_err;
  logic [15:0]  drop_cnt;
  logic [3:0]   fifo_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mesh_route_stage #(
    .PCKG_SZ    (P),
    .FIFO_DEPTH (8),
    .ROWS       (4),
    .COLS       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .id_r     (id_r),
    .id_c     (id_c),
    .in_data  (in_data),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_dir  (out_dir),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .drop_err (drop_err),
    .drop_cnt (drop_cnt),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [P-1:0] mk(input logic [7:0] nj, input logic [3:0] tr,
                                      input logic [3:0] tc, input logic md,
                                      input logic [3:0] src, input logic [3:0] pid,
                                      input logic [24:0] pl);
    return {nj, tr, tc, md, src, pid, pl};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [P-1:0] pkt, output logic acc);
    in_data = pkt;
    in_vld  = 1'b1;
    acc     = in_rdy;
    tick();
    in_vld  = 1'b0;
  endtask

  task automatic wait_vld(output int cycles);
    cycles = 0;
    while (!out_vld && cycles < 10) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset;
    tick();
    tick();
    n_checks++; if (fifo_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_rdy got %b want 0", in_rdy); end
    n_checks++; if (out_vld !== 1'b0 || out_dir !== 5'b0 || out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_out got vld=%b dir=%b data=%h want 0", out_vld, out_dir, out_data); end
    n_checks++; if (drop_err !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_drop got err=%b cnt=%0d want 0", drop_err, drop_cnt); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_in_rdy got %b want 1", in_rdy); end
  endtask

  task automatic test_latency;
    logic [P-1:0] pkt, exp;
    logic acc;
    pkt = mk(8'hA5, 4'd3, 4'd2, 1'b1, 4'h7, 4'h4, 25'h1F0F0F0);
    exp = mk(8'h22, 4'd3, 4'd2, 1'b1, 4'h7, 4'h4, 25'h1F0F0F0);
    out_rdy = 1'b1;
    push_pkt(pkt, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_accept got %b want 1", acc); end
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_k0 got vld=%b want 0", out_vld); end
    tick();
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_k1 got vld=%b want 0", out_vld); end
    tick();
    n_checks++; if (out_vld !== 1'b1 || out_dir !== EXP_S) begin n_fail++; $display("[TB] FAIL lat_k2 got vld=%b dir=%b want 1 %b", out_vld, out_dir, EXP_S); end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("[TB] FAIL lat_data got %h want %h", out_data, exp); end
    tick();
    n_checks++; if (out_vld !== 1'b0 || out_dir !== 5'b0) begin n_fail++; $display("[TB] FAIL lat_after got vld=%b dir=%b want 0 0", out_vld, out_dir); end
  endtask

  task automatic test_routes;
    logic [3:0] tr [7] = '{4'd3, 4'd0, 4'd0, 4'd1, 4'd1, 4'd3, 4'd1};
    logic [3:0] tc [7] = '{4'd2, 4'd3, 4'd3, 4'd0, 4'd2, 4'd2, 4'd3};
    logic       md [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] ed [7] = '{EXP_S, EXP_N, EXP_E, EXP_W, EXP_L, EXP_S, EXP_E};
    logic [7:0] en [7] = '{8'h22, 8'h02, 8'h13, 8'h11, 8'h12, 8'h22, 8'h13};
    logic [P-1:0] exp;
    logic acc;
    int cyc;
    out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_pkt(mk(8'h5A, tr[i], tc[i], md[i], 4'h9, 4'(i), 25'h0ABCDE + 25'(i)), acc);
      exp = mk(en[i], tr[i], tc[i], md[i], 4'h9, 4'(i), 25'h0ABCDE + 25'(i));
      wait_vld(cyc);
      n_checks++; if (acc !== 1'b1 || out_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL route%0d_vld got acc=%b vld=%b want 1 1", i, acc, out_vld); end
      n_checks++; if (out_dir !== ed[i]) begin n_fail++; $display("[TB] FAIL route%0d_dir got %b want %b", i, out_dir, ed[i]); end
      n_checks++; if (out_data !== exp) begin n_fail++; $display("[TB] FAIL route%0d_data got %h want %h", i, out_data, exp); end
      tick();
    end
  endtask

  task automatic test_drop;
    logic [P-1:0] exp;
    logic acc;
    int pulses, vlds, cyc;
    out_rdy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) push_pkt(mk(8'h00, 4'd5, 4'd1, 1'b1, 4'h1, 4'h1, 25'h1), acc);
      else        push_pkt(mk(8'h00, 4'd2, 4'd4, 1'b0, 4'h1, 4'h2, 25'h2), acc);
      pulses = 0;
      vlds   = 0;
      for (int c = 0; c < 6; c++) begin
        if (drop_err) pulses++;
        if (out_vld) vlds++;
        tick();
      end
      n_checks++; if (pulses != 1 || vlds != 0) begin n_fail++; $display("[TB] FAIL drop%0d_pulse got pulses=%0d vld_cycles=%0d want 1 0", d, pulses, vlds); end
      n_checks++; if (drop_cnt !== 16'(d + 1)) begin n_fail++; $display("[TB] FAIL drop%0d_cnt got %0d want %0d", d, drop_cnt, d + 1); end
    end
    push_pkt(mk(8'hFF, 4'd2, 4'd2, 1'b1, 4'h3, 4'h3, 25'h155), acc);
    exp = mk(8'h22, 4'd2, 4'd2, 1'b1, 4'h3, 4'h3, 25'h155);
    wait_vld(cyc);
    n_checks++; if (out_vld !== 1'b1 || out_dir !== EXP_S || out_data !== exp) begin n_fail++; $display("[TB] FAIL drop_follow got vld=%b dir=%b data=%h want 1 %b %h", out_vld, out_dir, out_data, EXP_S, exp); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [P-1:0] exp;
    logic will;
    int accepted;
    out_rdy  = 1'b0;
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      in_data = mk(8'h00, 4'd3, 4'd2, 1'b1, 4'h6, 4'h6, 25'(accepted));
      in_vld  = 1'b1;
      will    = in_rdy;
      tick();
      if (will) accepted++;
    end
    in_vld = 1'b0;
    n_checks++; if (accepted != 9) begin n_fail++; $display("[TB] FAIL bp_accepted got %0d want 9", accepted); end
    n_checks++; if (in_rdy !== 1'b0 || fifo_cnt !== 4'd8) begin n_fail++; $display("[TB] FAIL bp_full got in_rdy=%b cnt=%0d want 0 8", in_rdy, fifo_cnt); end
    exp = mk(8'h22, 4'd3, 4'd2, 1'b1, 4'h6, 4'h6, 25'd0);
    n_checks++; if (out_vld !== 1'b1 || out_data !== exp) begin n_fail++; $display("[TB] FAIL bp_hold got vld=%b data=%h want 1 %h", out_vld, out_data, exp); end
    out_rdy = 1'b1;
    for (int j = 0; j < 9; j++) begin
      exp = mk(8'h22, 4'd3, 4'd2, 1'b1, 4'h6, 4'h6, 25'(j));
      n_checks++; if (out_vld !== 1'b1 || out_dir !== EXP_S || out_data !== exp) begin n_fail++; $display("[TB] FAIL drain%0d got vld=%b dir=%b data=%h want 1 %b %h", j, out_vld, out_dir, out_data, EXP_S, exp); end
      tick();
    end
    n_checks++; if (out_vld !== 1'b0 || fifo_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL drain_end got vld=%b cnt=%0d want 0 0", out_vld, fifo_cnt); end
  endtask

  task automatic test_reset_midflight;
    logic [P-1:0] exp;
    logic acc;
    int vlds, cyc;
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_pkt(mk(8'h00, 4'd0, 4'd0, 1'b1, 4'h2, 4'(i), 25'h3000 + 25'(i)), acc);
    end
    n_checks++; if (fifo_cnt !== 4'd3 || out_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre got cnt=%0d vld=%b want 3 1", fifo_cnt, out_vld); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (fifo_cnt !== 4'd0 || out_vld !== 1'b0 || in_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async got cnt=%0d vld=%b in_rdy=%b want 0 0 0", fifo_cnt, out_vld, in_rdy); end
    n_checks++; if (out_dir !== 5'b0 || out_data !== '0 || drop_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_async_out got dir=%b data=%h drop_cnt=%0d want 0", out_dir, out_data, drop_cnt); end
    tick();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    tick();
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_release_in_rdy got %b want 1", in_rdy); end
    vlds = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_vld) vlds++;
      tick();
    end
    n_checks++; if (vlds != 0 || fifo_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_stale got vld_cycles=%0d cnt=%0d want 0 0", vlds, fifo_cnt); end
    push_pkt(mk(8'h77, 4'd1, 4'd2, 1'b0, 4'hC, 4'hD, 25'h1234567), acc);
    exp = mk(8'h12, 4'd1, 4'd2, 1'b0, 4'hC, 4'hD, 25'h1234567);
    wait_vld(cyc);
    n_checks++; if (out_vld !== 1'b1 || out_dir !== EXP_L || out_data !== exp) begin n_fail++; $display("[TB] FAIL mid_local got vld=%b dir=%b data=%h want 1 %b %h", out_vld, out_dir, out_data, EXP_L, exp); end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_routes();
    test_drop();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
